// File: rtl/apb_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_arb_pkg
// Shared types and packet layout for the APB command arbiter and the APB
// master stub it feeds.
//
// Contents:
//   arb_state_t    - arbiter FSM state (IDLE / GRANT)
//   *_LSB, *_BIT   - command/response packet field offsets for the default
//                    32-bit address / 32-bit data configuration
//   PKT_MAX_WIDTH  - widest command packet the helper function accepts
//   cmd_is_write   - returns pwrite (the packet MSB) of a command packet
// ---------------------------------------------------------------------------
package apb_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Default bus widths the stub is normally built with.
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   // Command packet {pwrite, pprot[2:0], pstrb, paddr, pwdata}, LSB first.
   localparam int PWDATA_LSB           = 0;
   localparam int PADDR_LSB            = PWDATA_LSB + DEF_DATA_WIDTH;
   localparam int PSTRB_LSB            = PADDR_LSB + DEF_ADDR_WIDTH;
   localparam int PPROT_LSB            = PSTRB_LSB + DEF_DATA_WIDTH / 8;
   localparam int PWRITE_BIT           = PPROT_LSB + 3;
   localparam int DEF_CMD_PACKET_WIDTH = PWRITE_BIT + 1;

   // Response packet {pslverr[1:0], prdata}.
   localparam int PRDATA_LSB            = 0;
   localparam int PSLVERR_LSB           = PRDATA_LSB + DEF_DATA_WIDTH;
   localparam int DEF_RESP_PACKET_WIDTH = PSLVERR_LSB + 2;

   // The helper works on a zero-extended copy so one function serves every
   // packet width up to this limit.
   localparam int PKT_MAX_WIDTH = 1024;

   // pwrite always sits in the top bit of the packet, whatever its width.
   function automatic logic cmd_is_write(input logic [PKT_MAX_WIDTH-1:0] pkt,
                                         input int unsigned              pkt_width);
      logic [9:0] msb;
      msb = 10'(pkt_width - 1);
      return pkt[msb];
   endfunction

endpackage : apb_arb_pkg

// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
// Purely combinational round-robin pick: returns the first requester found
// at or after the pointer, wrapping past the last client back to client 0.
//
// Ports:
//   req        in   N       request vector (already masked for eligibility)
//   ptr        in   IDW     highest-priority client this round
//   grant_id   out  IDW     encoded winner (0 when nothing requests)
//   any_grant  out  1       at least one request present
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] grant_id,
   output logic           any_grant
);

   // One extra bit so ptr+k never overflows before the modulo fold.
   localparam int SW = IDW + 1;

   logic [SW-1:0]  sum;
   logic [IDW-1:0] idx;

   // Scan N positions starting at ptr; the first hit wins and later hits
   // are ignored because any_grant is already set.
   always_comb begin
      grant_id  = '0;
      any_grant = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
         end
         idx = sum[IDW-1:0];
         if (!any_grant && req[idx]) begin
            any_grant = 1'b1;
            grant_id  = idx;
         end
      end
   end

endmodule : apb_rr_arbiter

// File: rtl/apb_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// apb_cmd_arbiter
// Shares one APB master stub between NUM_CLIENTS command sources. Commands
// are granted round-robin; every read that is handed to the stub has its
// client ID pushed into an in-order FIFO so the matching response can be
// routed back. Writes produce no response and are not tracked.
//
// Ports:
//   aclk, areset    in   clock, synchronous active-high reset
//   s_cmd_valid     in   per-client command valid
//   s_cmd_ready     out  per-client command ready
//   s_cmd_data      in   client i packet at [i*CMD_PACKET_WIDTH +: CMD_PACKET_WIDTH]
//   s_rsp_valid     out  per-client response valid
//   s_rsp_ready     in   per-client response ready
//   s_rsp_data      out  response packet, broadcast to all clients
//   m_cmd_valid     out  command valid to the stub
//   m_cmd_ready     in   command ready from the stub
//   m_cmd_data      out  command packet to the stub
//   m_rsp_valid     in   response valid from the stub
//   m_rsp_ready     out  response ready to the stub
//   m_rsp_data      in   response packet from the stub
//   o_grant_id      out  current / last granted client
//   o_outstanding   out  reads issued whose response has not returned
//   o_rsp_orphan    out  sticky: response seen with no read outstanding
// ---------------------------------------------------------------------------
module apb_cmd_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_CLIENTS       = 4,
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 32,
   parameter int CMD_PACKET_WIDTH  = ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 4,
   parameter int RESP_PACKET_WIDTH = DATA_WIDTH + 2,
   parameter int MAX_OUTSTANDING   = 4
) (
   input  logic                                    aclk,
   input  logic                                    areset,
   input  logic [NUM_CLIENTS-1:0]                  s_cmd_valid,
   output logic [NUM_CLIENTS-1:0]                  s_cmd_ready,
   input  logic [NUM_CLIENTS*CMD_PACKET_WIDTH-1:0] s_cmd_data,
   output logic [NUM_CLIENTS-1:0]                  s_rsp_valid,
   input  logic [NUM_CLIENTS-1:0]                  s_rsp_ready,
   output logic [RESP_PACKET_WIDTH-1:0]            s_rsp_data,
   output logic                                    m_cmd_valid,
   input  logic                                    m_cmd_ready,
   output logic [CMD_PACKET_WIDTH-1:0]             m_cmd_data,
   input  logic                                    m_rsp_valid,
   output logic                                    m_rsp_ready,
   input  logic [RESP_PACKET_WIDTH-1:0]            m_rsp_data,
   output logic [$clog2(NUM_CLIENTS)-1:0]          o_grant_id,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]    o_outstanding,
   output logic                                    o_rsp_orphan
);

   localparam int IDW  = $clog2(NUM_CLIENTS);
   localparam int AW   = $clog2(MAX_OUTSTANDING);
   localparam int PTRW = AW + 1;
   localparam int OUTW = $clog2(MAX_OUTSTANDING + 1);

   arb_state_t state;
   arb_state_t next_state;

   logic [IDW-1:0]         r_grant;
   logic [IDW-1:0]         rr_ptr;
   logic [IDW-1:0]         pick_id;
   logic                   pick_valid;
   logic [NUM_CLIENTS-1:0] eligible;

   logic [CMD_PACKET_WIDTH-1:0] grant_pkt;
   logic                        cmd_hs;
   logic                        push;
   logic                        pop;

   logic [IDW-1:0]  id_fifo [MAX_OUTSTANDING];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic [PTRW-1:0] fill;
   logic            fifo_full;
   logic            fifo_empty;
   logic [IDW-1:0]  head_id;
   logic            orphan;

   // Pointers carry one extra wrap bit, so the difference is the fill level
   // and full/empty never alias.
   assign fill       = wr_ptr - rd_ptr;
   assign fifo_full  = (fill == PTRW'(MAX_OUTSTANDING));
   assign fifo_empty = (fill == '0);
   assign head_id    = id_fifo[rd_ptr[AW-1:0]];

   // A read may only be granted while a FIFO slot is free. This looks at
   // the registered fill level on purpose: a pop in the same cycle does not
   // make a read eligible until the next cycle.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         eligible[i] = s_cmd_valid[i] &&
            !(!cmd_is_write(PKT_MAX_WIDTH'(s_cmd_data[i*CMD_PACKET_WIDTH +: CMD_PACKET_WIDTH]),
                            CMD_PACKET_WIDTH) && fifo_full);
      end
   end

   apb_rr_arbiter #(
      .N   (NUM_CLIENTS),
      .IDW (IDW)
   ) u_rr (
      .req       (eligible),
      .ptr       (rr_ptr),
      .grant_id  (pick_id),
      .any_grant (pick_valid)
   );

   // The packet is taken live from the granted client, which must hold it
   // stable until it sees ready.
   assign grant_pkt = s_cmd_data[r_grant*CMD_PACKET_WIDTH +: CMD_PACKET_WIDTH];
   assign cmd_hs    = (state == GRANT) && m_cmd_ready;
   assign push      = cmd_hs && !cmd_is_write(PKT_MAX_WIDTH'(grant_pkt), CMD_PACKET_WIDTH);

   // FSM state register.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic. Once in GRANT the selection is held until the
   // stub accepts it, even if the client misbehaves and drops valid.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               next_state = GRANT;
            end
         end
         GRANT: begin
            if (m_cmd_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs: only the granted client sees the stub's ready.
   always_comb begin
      m_cmd_valid = 1'b0;
      m_cmd_data  = '0;
      s_cmd_ready = '0;
      if (state == GRANT) begin
         m_cmd_valid          = 1'b1;
         m_cmd_data           = grant_pkt;
         s_cmd_ready[r_grant] = m_cmd_ready;
      end
   end

   // Grant is captured on leaving IDLE; the round-robin pointer only moves
   // past a client once its command has actually been accepted.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_grant <= '0;
         rr_ptr  <= '0;
      end else begin
         if ((state == IDLE) && pick_valid) begin
            r_grant <= pick_id;
         end
         if (cmd_hs) begin
            rr_ptr <= (r_grant == IDW'(NUM_CLIENTS - 1)) ? '0 : r_grant + 1'b1;
         end
      end
   end

   // Owner-ID storage has no reset; only the pointers define what is valid.
   always_ff @(posedge aclk) begin
      if (push) begin
         id_fifo[wr_ptr[AW-1:0]] <= r_grant;
      end
   end

   // Push and pop are independent, so a simultaneous pair leaves the fill
   // level unchanged.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Responses go to the FIFO head. With nothing outstanding the stub is
   // drained so a stray response cannot wedge it. While reset is held the
   // response path is closed, as the stub is being reset alongside.
   always_comb begin
      s_rsp_valid = '0;
      m_rsp_ready = 1'b0;
      if (!areset) begin
         if (!fifo_empty) begin
            s_rsp_valid[head_id] = m_rsp_valid;
            m_rsp_ready          = s_rsp_ready[head_id];
         end else begin
            m_rsp_ready = 1'b1;
         end
      end
   end

   assign pop        = m_rsp_valid && m_rsp_ready && !fifo_empty;
   assign s_rsp_data = m_rsp_data;

   // Sticky flag for a response that had no read waiting for it.
   always_ff @(posedge aclk) begin
      if (areset) begin
         orphan <= 1'b0;
      end else if (fifo_empty && m_rsp_valid) begin
         orphan <= 1'b1;
      end
   end

   assign o_grant_id    = r_grant;
   assign o_outstanding = OUTW'(fill);
   assign o_rsp_orphan  = orphan;

endmodule : apb_cmd_arbiter

// File: tb/tb_apb_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_arbiter
// Directed bench for apb_cmd_arbiter (4 clients, 32/32 widths, 4 reads
// outstanding). Inputs change 1ns after a rising edge and outputs are
// sampled 1ns after that, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_apb_cmd_arbiter;
   import apb_arb_pkg::*;

   localparam int NC  = 4;
   localparam int CPW = DEF_CMD_PACKET_WIDTH;
   localparam int RPW = DEF_RESP_PACKET_WIDTH;

   typedef logic [127:0] word_t;

   logic              aclk = 1'b0;
   logic              areset;
   logic [NC-1:0]     s_cmd_valid;
   logic [NC-1:0]     s_cmd_ready;
   logic [NC*CPW-1:0] s_cmd_data;
   logic [NC-1:0]     s_rsp_valid;
   logic [NC-1:0]     s_rsp_ready;
   logic [RPW-1:0]    s_rsp_data;
   logic              m_cmd_valid;
   logic              m_cmd_ready;
   logic [CPW-1:0]    m_cmd_data;
   logic              m_rsp_valid;
   logic              m_rsp_ready;
   logic [RPW-1:0]    m_rsp_data;
   logic [1:0]        o_grant_id;
   logic [2:0]        o_outstanding;
   logic              o_rsp_orphan;

   int errors = 0;
   int checks = 0;

   apb_cmd_arbiter #(
      .NUM_CLIENTS       (NC),
      .ADDR_WIDTH        (DEF_ADDR_WIDTH),
      .DATA_WIDTH        (DEF_DATA_WIDTH),
      .CMD_PACKET_WIDTH  (CPW),
      .RESP_PACKET_WIDTH (RPW),
      .MAX_OUTSTANDING   (4)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_cmd_valid   (s_cmd_valid),
      .s_cmd_ready   (s_cmd_ready),
      .s_cmd_data    (s_cmd_data),
      .s_rsp_valid   (s_rsp_valid),
      .s_rsp_ready   (s_rsp_ready),
      .s_rsp_data    (s_rsp_data),
      .m_cmd_valid   (m_cmd_valid),
      .m_cmd_ready   (m_cmd_ready),
      .m_cmd_data    (m_cmd_data),
      .m_rsp_valid   (m_rsp_valid),
      .m_rsp_ready   (m_rsp_ready),
      .m_rsp_data    (m_rsp_data),
      .o_grant_id    (o_grant_id),
      .o_outstanding (o_outstanding),
      .o_rsp_orphan  (o_rsp_orphan)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [CPW-1:0] make_pkt(input logic wr, input logic [31:0] addr,
                                               input logic [31:0] data);
      logic [CPW-1:0] p;
      p                    = '0;
      p[PWRITE_BIT]        = wr;
      p[PSTRB_LSB +: 4]    = 4'hF;
      p[PADDR_LSB +: 32]   = addr;
      p[PWDATA_LSB +: 32]  = data;
      return p;
   endfunction

   task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int c, input logic valid, input logic [CPW-1:0] pkt);
      s_cmd_valid[c]           = valid;
      s_cmd_data[c*CPW +: CPW] = pkt;
   endtask

   task automatic step_clock();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      step_clock();
      step_clock();
      areset = 1'b0;
   endtask

   // Present a command, wait (bounded) for its ready, let it hand off, drop it.
   task automatic issue_cmd(input int c, input logic [CPW-1:0] pkt);
      logic seen;
      applyStimulus(c, 1'b1, pkt);
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
         step_clock();
         seen = s_cmd_ready[c];
      end
      checkOutput("issue_ready", word_t'(seen), word_t'(1'b1));
      step_clock();
      applyStimulus(c, 1'b0, '0);
   endtask

   logic [CPW-1:0] pkts [NC];
   logic [CPW-1:0] pkt_w0;
   logic [CPW-1:0] pkt_r;
   logic [RPW-1:0] rsp [5];
   logic [NC-1:0]  exp_ready;

   initial begin
      areset      = 1'b1;
      s_cmd_valid = '0;
      s_cmd_data  = '0;
      s_rsp_ready = '0;
      m_cmd_ready = 1'b1;
      m_rsp_valid = 1'b0;
      m_rsp_data  = '0;
      for (int i = 0; i < NC; i++) pkts[i] = make_pkt(1'b1, 32'h100 + i, 32'hC0DE_0000 + i);
      for (int i = 0; i < 5; i++)  rsp[i]  = {2'b00, 32'h1111_0000 + i};

      // Reset state.
      step_clock();
      step_clock();
      checkOutput("rst_m_cmd_valid", word_t'(m_cmd_valid), word_t'(0));
      checkOutput("rst_s_cmd_ready", word_t'(s_cmd_ready), word_t'(0));
      checkOutput("rst_s_rsp_valid", word_t'(s_rsp_valid), word_t'(0));
      checkOutput("rst_m_rsp_ready", word_t'(m_rsp_ready), word_t'(0));
      checkOutput("rst_grant_id", word_t'(o_grant_id), word_t'(0));
      checkOutput("rst_outstanding", word_t'(o_outstanding), word_t'(0));
      checkOutput("rst_orphan", word_t'(o_rsp_orphan), word_t'(0));
      areset = 1'b0;
      #1;
      checkOutput("drain_ready_empty", word_t'(m_rsp_ready), word_t'(1));

      // Single write from client 0.
      pkt_w0 = make_pkt(1'b1, 32'h10, 32'hA5A5_A5A5);
      applyStimulus(0, 1'b1, pkt_w0);
      #1;
      checkOutput("w0_no_valid_yet", word_t'(m_cmd_valid), word_t'(0));
      step_clock();
      checkOutput("w0_m_cmd_valid", word_t'(m_cmd_valid), word_t'(1));
      checkOutput("w0_m_cmd_data", word_t'(m_cmd_data), word_t'(pkt_w0));
      checkOutput("w0_s_cmd_ready", word_t'(s_cmd_ready), word_t'(4'b0001));
      checkOutput("w0_grant_id", word_t'(o_grant_id), word_t'(0));
      step_clock();
      applyStimulus(0, 1'b0, '0);
      #1;
      checkOutput("w0_ready_pulse_done", word_t'(s_cmd_ready), word_t'(0));
      checkOutput("w0_valid_dropped", word_t'(m_cmd_valid), word_t'(0));
      checkOutput("w0_outstanding", word_t'(o_outstanding), word_t'(0));

      // All four clients request writes continuously from reset.
      do_reset();
      for (int i = 0; i < NC; i++) applyStimulus(i, 1'b1, pkts[i]);
      for (int k = 0; k < 9; k++) begin
         step_clock();
         exp_ready = (k % 2 == 0) ? NC'(1 << ((k / 2) % NC)) : '0;
         checkOutput("rr_s_cmd_ready", word_t'(s_cmd_ready), word_t'(exp_ready));
         if (k % 2 == 0) begin
            checkOutput("rr_grant_id", word_t'(o_grant_id), word_t'((k / 2) % NC));
            checkOutput("rr_m_cmd_data", word_t'(m_cmd_data), word_t'(pkts[(k / 2) % NC]));
         end
      end
      step_clock();
      for (int i = 0; i < NC; i++) applyStimulus(i, 1'b0, '0);

      // Client 2 read and its response.
      pkt_r = make_pkt(1'b0, 32'h20, 32'h0);
      applyStimulus(2, 1'b1, pkt_r);
      step_clock();
      checkOutput("r2_s_cmd_ready", word_t'(s_cmd_ready), word_t'(4'b0100));
      checkOutput("r2_m_cmd_data", word_t'(m_cmd_data), word_t'(pkt_r));
      step_clock();
      applyStimulus(2, 1'b0, '0);
      #1;
      checkOutput("r2_outstanding_1", word_t'(o_outstanding), word_t'(1));
      checkOutput("r2_rsp_ready_low", word_t'(m_rsp_ready), word_t'(0));
      s_rsp_ready = 4'hF;
      m_rsp_valid = 1'b1;
      m_rsp_data  = {2'b00, 32'hDEAD_BEEF};
      #1;
      checkOutput("r2_s_rsp_valid", word_t'(s_rsp_valid), word_t'(4'b0100));
      checkOutput("r2_s_rsp_data", word_t'(s_rsp_data), word_t'({2'b00, 32'hDEAD_BEEF}));
      checkOutput("r2_m_rsp_ready", word_t'(m_rsp_ready), word_t'(1));
      step_clock();
      m_rsp_valid = 1'b0;
      #1;
      checkOutput("r2_outstanding_0", word_t'(o_outstanding), word_t'(0));
      checkOutput("r2_no_orphan", word_t'(o_rsp_orphan), word_t'(0));

      // Fill the FIFO with reads from clients 1,3,1,0.
      issue_cmd(1, make_pkt(1'b0, 32'h40, 32'h0));
      issue_cmd(3, make_pkt(1'b0, 32'h44, 32'h0));
      issue_cmd(1, make_pkt(1'b0, 32'h48, 32'h0));
      issue_cmd(0, make_pkt(1'b0, 32'h4C, 32'h0));
      #1;
      checkOutput("full_outstanding_4", word_t'(o_outstanding), word_t'(4));

      // Client 2 read blocked while full; client 0 write goes through.
      applyStimulus(2, 1'b1, pkt_r);
      applyStimulus(0, 1'b1, pkt_w0);
      step_clock();
      checkOutput("full_write_granted", word_t'(s_cmd_ready), word_t'(4'b0001));
      checkOutput("full_write_grant_id", word_t'(o_grant_id), word_t'(0));
      step_clock();
      applyStimulus(0, 1'b0, '0);
      for (int n = 0; n < 3; n++) begin
         step_clock();
         checkOutput("full_read_blocked", word_t'(m_cmd_valid), word_t'(0));
      end

      // Responses route 1,3,1,0; client 2 gets in as slots free up.
      m_rsp_valid = 1'b1;
      m_rsp_data  = rsp[0];
      #1;
      checkOutput("route_1a_valid", word_t'(s_rsp_valid), word_t'(4'b0010));
      checkOutput("route_1a_data", word_t'(s_rsp_data), word_t'(rsp[0]));
      step_clock();
      m_rsp_data = rsp[1];
      #1;
      checkOutput("route_3_valid", word_t'(s_rsp_valid), word_t'(4'b1000));
      checkOutput("route_3_outstanding", word_t'(o_outstanding), word_t'(3));
      checkOutput("route_3_still_blocked", word_t'(m_cmd_valid), word_t'(0));
      step_clock();
      m_rsp_data = rsp[2];
      #1;
      checkOutput("route_1b_valid", word_t'(s_rsp_valid), word_t'(4'b0010));
      checkOutput("r2_late_grant", word_t'(s_cmd_ready), word_t'(4'b0100));
      checkOutput("route_1b_outstanding", word_t'(o_outstanding), word_t'(2));
      step_clock();
      applyStimulus(2, 1'b0, '0);
      m_rsp_data = rsp[3];
      #1;
      checkOutput("push_pop_outstanding", word_t'(o_outstanding), word_t'(2));
      checkOutput("route_0_valid", word_t'(s_rsp_valid), word_t'(4'b0001));
      checkOutput("route_0_data", word_t'(s_rsp_data), word_t'(rsp[3]));
      step_clock();
      m_rsp_data  = rsp[4];
      s_rsp_ready = 4'b1011;
      #1;
      checkOutput("route_2_valid", word_t'(s_rsp_valid), word_t'(4'b0100));
      checkOutput("bp_m_rsp_ready", word_t'(m_rsp_ready), word_t'(0));

      // Head client holds off for three cycles.
      for (int n = 0; n < 3; n++) begin
         step_clock();
         checkOutput("bp_hold_ready", word_t'(m_rsp_ready), word_t'(0));
         checkOutput("bp_hold_valid", word_t'(s_rsp_valid), word_t'(4'b0100));
         checkOutput("bp_hold_data", word_t'(s_rsp_data), word_t'(rsp[4]));
         checkOutput("bp_hold_outstanding", word_t'(o_outstanding), word_t'(1));
      end
      s_rsp_ready = 4'hF;
      #1;
      checkOutput("bp_release_ready", word_t'(m_rsp_ready), word_t'(1));
      step_clock();
      m_rsp_valid = 1'b0;
      #1;
      checkOutput("bp_outstanding_0", word_t'(o_outstanding), word_t'(0));
      checkOutput("bp_no_orphan", word_t'(o_rsp_orphan), word_t'(0));

      // Response with nothing outstanding.
      m_rsp_valid = 1'b1;
      m_rsp_data  = {2'b10, 32'hBAD0_BAD0};
      #1;
      checkOutput("orphan_drain_ready", word_t'(m_rsp_ready), word_t'(1));
      checkOutput("orphan_no_rsp_valid", word_t'(s_rsp_valid), word_t'(0));
      step_clock();
      m_rsp_valid = 1'b0;
      #1;
      checkOutput("orphan_set", word_t'(o_rsp_orphan), word_t'(1));
      step_clock();
      step_clock();
      checkOutput("orphan_sticky", word_t'(o_rsp_orphan), word_t'(1));

      // Reset while a grant is stalled and a read is outstanding.
      issue_cmd(3, make_pkt(1'b0, 32'h80, 32'h0));
      #1;
      checkOutput("pre_rst_outstanding", word_t'(o_outstanding), word_t'(1));
      m_cmd_ready = 1'b0;
      applyStimulus(1, 1'b1, pkts[1]);
      step_clock();
      checkOutput("stall_valid", word_t'(m_cmd_valid), word_t'(1));
      checkOutput("stall_grant_id", word_t'(o_grant_id), word_t'(1));
      checkOutput("stall_no_ready", word_t'(s_cmd_ready), word_t'(0));
      step_clock();
      checkOutput("stall_hold_valid", word_t'(m_cmd_valid), word_t'(1));
      checkOutput("stall_hold_data", word_t'(m_cmd_data), word_t'(pkts[1]));
      areset = 1'b1;
      step_clock();
      checkOutput("mid_rst_m_cmd_valid", word_t'(m_cmd_valid), word_t'(0));
      checkOutput("mid_rst_m_cmd_data", word_t'(m_cmd_data), word_t'(0));
      checkOutput("mid_rst_s_cmd_ready", word_t'(s_cmd_ready), word_t'(0));
      checkOutput("mid_rst_grant_id", word_t'(o_grant_id), word_t'(0));
      checkOutput("mid_rst_outstanding", word_t'(o_outstanding), word_t'(0));
      checkOutput("mid_rst_orphan", word_t'(o_rsp_orphan), word_t'(0));
      checkOutput("mid_rst_m_rsp_ready", word_t'(m_rsp_ready), word_t'(0));
      checkOutput("mid_rst_s_rsp_valid", word_t'(s_rsp_valid), word_t'(0));
      areset = 1'b0;
      applyStimulus(1, 1'b0, '0);
      m_cmd_ready = 1'b1;
      #1;
      checkOutput("post_rst_drain_ready", word_t'(m_rsp_ready), word_t'(1));
      step_clock();
      checkOutput("post_rst_idle", word_t'(m_cmd_valid), word_t'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_apb_cmd_arbiter
